// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode controller: run/pause/adjust/clear sequencing for the min/sec counter.
// Issues registered one-cycle count/adjust/clear strobes and the adjust blink mask.
module stopwatch_ctrl #(
  parameter int START_RUNNING = 1,
  parameter int BLINK_HALF    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       pause,
  input  logic       clear,
  input  logic       sel,
  input  logic       adj,
  output logic       run_inc,
  output logic       adj_inc_min,
  output logic       adj_inc_sec,
  output logic       cnt_clr,
  output logic       paused,
  output logic [1:0] state,
  output logic [3:0] blink_mask
);

  typedef enum logic [1:0] {
    S_RUN    = 2'b00,
    S_PAUSED = 2'b01,
    S_ADJUST = 2'b10,
    S_CLEAR  = 2'b11
  } state_t;

  localparam state_t RESET_STATE = (START_RUNNING != 0) ? S_RUN : S_PAUSED;
  localparam logic   RESET_SAVED = (START_RUNNING == 0);

  state_t     state_q, state_n;
  logic       saved_q, saved_n;
  logic       pause_q, clear_q;
  logic       phase_q, phase_n;
  logic [3:0] bcnt_q, bcnt_n;
  logic [3:0] bcnt_inc;
  logic       run_inc_n, adj_min_n, adj_sec_n, cnt_clr_n, paused_n;
  logic [3:0] mask_n;
  logic       pause_rise, clear_rise;

  assign pause_rise = pause & ~pause_q;
  assign clear_rise = clear & ~clear_q;
  assign bcnt_inc   = bcnt_q + 4'd1;
  assign state      = state_q;

  always_comb begin
    state_n   = state_q;
    saved_n   = saved_q;
    phase_n   = phase_q;
    bcnt_n    = bcnt_q;
    run_inc_n = 1'b0;
    adj_min_n = 1'b0;
    adj_sec_n = 1'b0;
    cnt_clr_n = 1'b0;

    if (clear_rise) begin
      // Clear pre-empts everything: concurrent pause edges and ticks are dropped.
      state_n   = S_CLEAR;
      saved_n   = 1'b1;
      cnt_clr_n = 1'b1;
    end else begin
      unique case (state_q)
        S_CLEAR: begin
          state_n = adj ? S_ADJUST : S_PAUSED;
          if (adj) begin
            phase_n = 1'b1;
            bcnt_n  = '0;
          end
        end
        S_RUN, S_PAUSED: begin
          run_inc_n = (state_q == S_RUN) & tick_1hz;
          if (adj) begin
            state_n = S_ADJUST;
            saved_n = (state_q == S_PAUSED);
            phase_n = 1'b1;
            bcnt_n  = '0;
          end else if (pause_rise) begin
            state_n = (state_q == S_RUN) ? S_PAUSED : S_RUN;
          end
        end
        S_ADJUST: begin
          if (!adj) begin
            state_n = saved_q ? S_PAUSED : S_RUN;
          end else if (pause_rise) begin
            saved_n = ~saved_q;
          end
          if (tick_2hz) begin
            adj_min_n = ~sel;
            adj_sec_n = sel;
            if (bcnt_inc == 4'(BLINK_HALF)) begin
              bcnt_n  = '0;
              phase_n = ~phase_q;
            end else begin
              bcnt_n = bcnt_inc;
            end
          end
        end
        default: state_n = RESET_STATE;
      endcase
    end

    mask_n = '0;
    if (state_n == S_ADJUST && !phase_n)
      mask_n = sel ? 4'b0011 : 4'b1100;

    paused_n = (state_n == S_PAUSED) | (state_n == S_CLEAR) |
               ((state_n == S_ADJUST) & saved_n);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RESET_STATE;
      saved_q     <= RESET_SAVED;
      pause_q     <= 1'b1;
      clear_q     <= 1'b1;
      phase_q     <= 1'b1;
      bcnt_q      <= '0;
      run_inc     <= 1'b0;
      adj_inc_min <= 1'b0;
      adj_inc_sec <= 1'b0;
      cnt_clr     <= 1'b0;
      paused      <= RESET_SAVED;
      blink_mask  <= '0;
    end else begin
      state_q     <= state_n;
      saved_q     <= saved_n;
      pause_q     <= pause;
      clear_q     <= clear;
      phase_q     <= phase_n;
      bcnt_q      <= bcnt_n;
      run_inc     <= run_inc_n;
      adj_inc_min <= adj_min_n;
      adj_inc_sec <= adj_sec_n;
      cnt_clr     <= cnt_clr_n;
      paused      <= paused_n;
      blink_mask  <= mask_n;
    end
  end

endmodule
